// File: rtl/ex_muldiv_pkg.sv
// Shared widths, RV32M operation encodings and FSM state type for the EX-stage multiply/divide unit.
package ex_muldiv_pkg;

    localparam int REG_DATA_WIDTH = 32;
    localparam int REG_ADDR_WIDTH = 5;

    localparam logic [2:0] MULDIV_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_REM    = 3'b110;
    localparam logic [2:0] MULDIV_REMU   = 3'b111;

    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    localparam int MULDIV_CYCLES = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } muldiv_state_e;

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
    function automatic logic opASigned(input logic [2:0] f3);
        return (f3 == MULDIV_MULH) || (f3 == MULDIV_MULHSU) ||
               (f3 == MULDIV_DIV)  || (f3 == MULDIV_REM);
    endfunction

    function automatic logic opBSigned(input logic [2:0] f3);
        return (f3 == MULDIV_MULH) || (f3 == MULDIV_DIV) || (f3 == MULDIV_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_datapath.sv
// Radix-2 multiply/divide datapath: 64-bit shift-add / restoring shift-subtract register
// plus the final sign-fix negation and result selection.
module muldiv_datapath
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = REG_DATA_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_loadDiv,
    input  logic            i_step,
    input  logic [XLEN-1:0] i_aMag,
    input  logic [XLEN-1:0] i_bMag,
    input  logic [2:0]      i_funct3,
    input  logic            i_negProd,
    input  logic            i_negRem,
    output logic [XLEN-1:0] o_fixResult
);

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;

    logic [2*XLEN-1:0] w_accNext;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_addend;
    logic [XLEN-1:0]   w_diffLow;
    logic [XLEN-1:0]   w_remNext;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_partial;
    logic              w_ge;

    // Multiply: conditional add of the multiplicand into the high half, then shift right.
    assign w_addend = r_acc[0] ? r_opnd : '0;
    assign w_sum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_addend};

    // Divide: the shifted partial remainder needs one extra bit before the compare.
    assign w_partial = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_ge      = (w_partial >= {1'b0, r_opnd});
    assign w_diffLow = w_partial[XLEN-1:0] - r_opnd;
    assign w_remNext = w_ge ? w_diffLow : w_partial[XLEN-1:0];

    assign w_accNext = i_funct3[2] ? {w_remNext, r_acc[XLEN-2:0], w_ge}
                                   : {w_sum, r_acc[XLEN-1:1]};

    assign w_prod = i_negProd ? -r_acc : r_acc;
    assign w_quot = i_negProd ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem  = i_negRem  ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    // MUL never carries sign flags, so its low word is the raw unsigned product.
    always_comb begin
        o_fixResult = w_prod[XLEN-1:0];
        case (i_funct3)
            MULDIV_MUL:                             o_fixResult = w_prod[XLEN-1:0];
            MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: o_fixResult = w_prod[2*XLEN-1:XLEN];
            MULDIV_DIV, MULDIV_DIVU:                o_fixResult = w_quot;
            default:                                o_fixResult = w_rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc  <= '0;
            r_opnd <= '0;
        end else if (i_load) begin
            r_opnd <= i_loadDiv ? i_bMag : i_aMag;
            r_acc  <= {{XLEN{1'b0}}, (i_loadDiv ? i_aMag : i_bMag)};
        end else if (i_step) begin
            r_acc <= w_accNext;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: stalls the front end while a
// 32-step radix-2 operation runs, then presents a one-cycle result beat to EX/MEM.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN    = REG_DATA_WIDTH,
    parameter int RADDR_W = REG_ADDR_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         funct3,
    input  logic [XLEN-1:0]    op_a,
    input  logic [XLEN-1:0]    op_b,
    input  logic [RADDR_W-1:0] rd_in,
    input  logic               flush,
    output logic               stall,
    output logic               done,
    output logic [XLEN-1:0]    result,
    output logic [RADDR_W-1:0] rd_out
);

    localparam int               CNT_W    = $clog2(MULDIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULDIV_CYCLES - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e r_state;
    muldiv_state_e w_nextState;

    logic [CNT_W-1:0]   r_count;
    logic [2:0]         r_funct3;
    logic               r_signA;
    logic               r_signB;
    logic [RADDR_W-1:0] r_rdHold;
    logic [RADDR_W-1:0] r_rdOut;
    logic [XLEN-1:0]    r_result;

    logic            w_accept;
    logic            w_divZero;
    logic            w_overflow;
    logic            w_special;
    logic            w_signA;
    logic            w_signB;
    logic            w_load;
    logic            w_step;
    logic [XLEN-1:0] w_aMag;
    logic [XLEN-1:0] w_bMag;
    logic [XLEN-1:0] w_specialResult;
    logic [XLEN-1:0] w_fixResult;

    assign w_accept = (r_state == ST_IDLE) && start && !flush;

    assign w_signA = opASigned(funct3) & op_a[XLEN-1];
    assign w_signB = opBSigned(funct3) & op_b[XLEN-1];
    assign w_aMag  = w_signA ? -op_a : op_a;
    assign w_bMag  = w_signB ? -op_b : op_b;

    // Divide-by-zero and signed overflow have fixed answers and skip the iteration.
    assign w_divZero  = funct3[2] && (op_b == '0);
    assign w_overflow = ((funct3 == MULDIV_DIV) || (funct3 == MULDIV_REM)) &&
                        (op_a == INT_MIN) && (op_b == {XLEN{1'b1}});
    assign w_special  = w_divZero || w_overflow;

    always_comb begin
        w_specialResult = op_a;
        if (w_divZero) begin
            w_specialResult = funct3[1] ? op_a : {XLEN{1'b1}};
        end else if (funct3[1]) begin
            w_specialResult = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_nextState = w_special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    w_nextState = ST_IDLE;
                end else if (r_count == CNT_LAST) begin
                    w_nextState = ST_FIX;
                end
            end
            ST_FIX:  w_nextState = flush ? ST_IDLE : ST_DONE;
            ST_DONE: w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // The front end must never see a stall while the unit is held in reset.
    always_comb begin
        stall  = 1'b0;
        done   = 1'b0;
        w_load = 1'b0;
        w_step = 1'b0;
        case (r_state)
            ST_IDLE: begin
                stall  = w_accept;
                w_load = w_accept && !w_special;
            end
            ST_CALC: begin
                stall  = 1'b1;
                w_step = 1'b1;
            end
            ST_FIX:  stall = 1'b1;
            ST_DONE: done  = 1'b1;
            default: ;
        endcase
        if (!rst) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count  <= '0;
            r_funct3 <= '0;
            r_signA  <= 1'b0;
            r_signB  <= 1'b0;
            r_rdHold <= '0;
            r_rdOut  <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_count  <= '0;
                r_funct3 <= funct3;
                r_signA  <= w_signA;
                r_signB  <= w_signB;
                r_rdHold <= rd_in;
                if (w_special) begin
                    r_result <= w_specialResult;
                    r_rdOut  <= rd_in;
                end
            end else if (r_state == ST_CALC) begin
                r_count <= r_count + 1'b1;
            end
            // Result and rd only change on entry to DONE; consumers qualify them with done.
            if ((r_state == ST_FIX) && !flush) begin
                r_result <= w_fixResult;
                r_rdOut  <= r_rdHold;
            end
        end
    end

    muldiv_datapath #(
        .XLEN(XLEN)
    ) u_datapath (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_loadDiv  (funct3[2]),
        .i_step     (w_step),
        .i_aMag     (w_aMag),
        .i_bMag     (w_bMag),
        .i_funct3   (r_funct3),
        .i_negProd  (r_signA ^ r_signB),
        .i_negRem   (r_signA),
        .o_fixResult(w_fixResult)
    );

    assign result = r_result;
    assign rd_out = r_rdOut;

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the EX stage.
- Consumes the ID/EX register's operand, rd and instruction-field outputs for M-extension instructions.
- Holds IF/ID and ID/EX with a stall while it computes, then presents a one-cycle result beat that EX/MEM captures.
- It is the consuming end of the ID/EX interface for multi-cycle operations.

Parameters:
- XLEN, 32, operand/result width (equals REG_DATA_WIDTH).
- RADDR_W, 5, destination register index width (equals REG_ADDR_WIDTH).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  ID/EX holds a valid M-extension instruction (opcode OP, funct7=0000001).
- funct3  input  3  ID/EX inst[14:12], selects the operation.
- op_a  input  XLEN  forwarded rs1 value.
- op_b  input  XLEN  forwarded rs2 value.
- rd_in  input  RADDR_W  ID/EX.rd.
- flush  input  1  kill the in-flight operation (taken branch / trap).
- stall  output  1  hold the PC, IF/ID and ID/EX.
- done  output  1  result valid this cycle.
- result  output  XLEN  operation result.
- rd_out  output  RADDR_W  destination register index for the result.

Behaviour:
- **States:** IDLE, CALC, FIX, DONE.
- **Reset:** while rst=0, state=IDLE, counter=0, done=0, result=0, rd_out=0, all datapath registers 0. The stall output is forced to 0 while rst=0.
- **funct3 encoding:** 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- **IDLE:**
  - start=1 and flush=0: latch operand magnitudes, sign flags, funct3 and rd_in.
  - Normal case: go to CALC with counter=0.
  - Special division case: go straight to DONE.
- **Signedness:**
  - MULH, DIV, REM: both operands signed.
  - MULHSU: op_a signed, op_b unsigned.
  - MUL, MULHU, DIVU, REMU: unsigned magnitudes.
  - MUL low word is sign-independent.
- **CALC:** one radix-2 step per cycle for exactly 32 cycles.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract.
  - At counter=31, go to FIX.
- **FIX:** one cycle.
  - Negate the product if the operand signs differ.
  - Negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Select the result: MUL = low word; MULH/MULHSU/MULHU = high word; quotient or remainder as selected.
  - Go to DONE.
- **DONE:** done=1, result and rd_out valid, stall=0. Always go to IDLE next cycle. start is ignored in DONE, because ID/EX still holds the same instruction.
- **stall:** `(state==IDLE && start && !flush) || state==CALC || state==FIX`.
- **Latency (normal):**
  - start seen in cycle 0; stall=1 in cycles 0..33.
  - done=1 in cycle 34.
  - A back-to-back M instruction is accepted in cycle 35.
- **Special division cases (resolved in IDLE, done in cycle 1, stall=1 in cycle 0 only):**
  - Divisor 0: DIV/DIVU give all ones; REM/REMU give op_a.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF, DIV/REM): DIV gives 0x80000000; REM gives 0.
- **flush:**
  - Synchronous, and has priority over start.
  - In CALC or FIX: next state is IDLE with no done pulse; stall drops in the cycle after flush.
  - In DONE: done is unaffected this cycle.
- **result hold:** result and rd_out keep their values outside DONE. Consumers qualify them with done.
- **Mid-operation reset:** aborts immediately; all outputs return to reset values.

Decomposition:
- Shared constants file (same one defining the data/addr widths), holds:
  - M-extension funct3 macros: MULDIV_MUL … MULDIV_REMU.
  - funct7 value 0000001.
  - MULDIV_CYCLES=32.
  - Two-bit state encodings.
- One natural sub-module, muldiv_datapath: 64-bit accumulator/remainder shift register, add/subtract step, and sign-fix negation. The FSM, counter and handshake stay in ex_muldiv.

Test Plan:
- MUL, op_a=7, op_b=0xFFFFFFFD (-3): result=0xFFFFFFEB; stall high cycles 0..33; done only in cycle 34.
- MULH 0x80000000*0x80000000 gives 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF gives 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF gives 0xFFFFFFFF.
- Divides with op_a=-7 (0xFFFFFFF9), op_b=2: DIV gives 0xFFFFFFFD; REM gives 0xFFFFFFFF. With op_a=7, op_b=2: DIVU gives 3; REMU gives 1.
- DIV 5/0 gives 0xFFFFFFFF and REM 5/0 gives 5, each with done in cycle 1. DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM gives 0.
- Start MUL, assert flush in cycle 10: no done, stall=0 from cycle 11. A new DIVU 100/7 started afterwards gives 14 at its cycle 34.
- Back-to-back MUL 3*4 then MUL 5*6 with start held: results 12 then 30, done in cycles 34 and 69. In a separate run, drive rst=0 in cycle 20 mid-CALC: stall, done, result and rd_out all 0 immediately.
